// File: rtl/jzjpcc_pkg.sv
// Shared types and constants for the jzjpcc core's fetch/decode boundary.
// NOP_INSTRUCTION is the canonical RV32I bubble (addi x0, x0, 0).
package jzjpcc_pkg;

   localparam logic [31:0] NOP_INSTRUCTION   = 32'h00000013;
   localparam logic [31:0] INSTRUCTION_BYTES = 32'd4;

   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] pc;
      logic [31:0] pcPlus4;
      logic        valid;
   } ifid_t;

endpackage

// File: rtl/jzjpcc_fetch.sv
// Instruction fetch: owns the PC, drives the backend read address, holds IF/ID.
// IF/ID fills 2 edges after reset release or redirect; stall freezes PC and IF/ID.
module jzjpcc_fetch
   import jzjpcc_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirectTarget,
   output logic [31:0] instructionAddress,
   input  logic [31:0] instructionFromMemory,
   output logic [31:0] ifidInstruction,
   output logic [31:0] ifidPC,
   output logic [31:0] ifidPCPlus4,
   output logic        ifidValid,
   output logic        misalignedTarget
);

   logic [31:0] r_pc;
   logic        r_mem_ready;
   logic        r_misaligned;
   ifid_t       r_ifid;

   logic [31:0] w_pc_next;
   logic [31:0] w_pc_plus4;

   assign w_pc_plus4 = r_pc + INSTRUCTION_BYTES;

   // Until memReady is set the backend has never captured r_pc, so hold it
   // one edge to let the reset vector itself be fetched.
   always_comb begin
      w_pc_next = w_pc_plus4;
      if (redirect)
         w_pc_next = {redirectTarget[31:2], 2'b00};
      else if (stall || !r_mem_ready)
         w_pc_next = r_pc;
   end

   assign instructionAddress = w_pc_next;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pc         <= RESET_VECTOR;
         r_mem_ready  <= 1'b0;
         r_misaligned <= 1'b0;
      end else begin
         r_pc         <= w_pc_next;
         r_mem_ready  <= 1'b1;
         r_misaligned <= redirect && (redirectTarget[1:0] != 2'b00);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ifid.instruction <= NOP_INSTRUCTION;
         r_ifid.pc          <= RESET_VECTOR;
         r_ifid.pcPlus4     <= RESET_VECTOR + INSTRUCTION_BYTES;
         r_ifid.valid       <= 1'b0;
      end else if (redirect) begin
         // Squash whatever was fetched down the wrong path; PC fields keep their value.
         r_ifid.instruction <= NOP_INSTRUCTION;
         r_ifid.valid       <= 1'b0;
      end else if (!stall) begin
         r_ifid.instruction <= instructionFromMemory;
         r_ifid.pc          <= r_pc;
         r_ifid.pcPlus4     <= w_pc_plus4;
         r_ifid.valid       <= r_mem_ready;
      end
   end

   assign ifidInstruction  = r_ifid.instruction;
   assign ifidPC           = r_ifid.pc;
   assign ifidPCPlus4      = r_ifid.pcPlus4;
   assign ifidValid        = r_ifid.valid;
   assign misalignedTarget = r_misaligned;

endmodule
